// File: rtl/alu_dec_pkg.sv
// Shared ALU-control, compare and load-width encodings plus the decoded-result struct
// used by the decode pipe and its combinational decoder.
package alu_dec_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_MEXT = 4'b1111;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_NZ   = 2'b10;
  localparam logic [1:0] CMP_ZERO = 2'b11;

  localparam logic [2:0] MEM_NONE = 3'b000;
  localparam logic [2:0] MEM_LB   = 3'b001;
  localparam logic [2:0] MEM_LH   = 3'b010;
  localparam logic [2:0] MEM_LW   = 3'b011;
  localparam logic [2:0] MEM_LBU  = 3'b101;
  localparam logic [2:0] MEM_LHU  = 3'b110;

  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    OP_R      = 2'b00,
    OP_I      = 2'b01,
    OP_LOAD   = 2'b10,
    OP_BRANCH = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] cmp;
    logic [2:0] mem;
    logic       mc;
    logic [2:0] mfn;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_dec_comb.sv
// Pure combinational decode of (instr, alu_op) into a dec_t; no state, zero latency.
// M-extension decoding of R-type funct7=0000001 exists only under ALU_DEC_MEXT_EN.
module alu_dec_comb
  import alu_dec_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [1:0]  alu_op,
  output dec_t        dec
);

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;
  logic       unused_bits;

  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign alt         = instr[30];
  assign unused_bits = ^{instr[24:15], instr[11:0]};

  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ALU_ADD;
    case (alu_op_e'(alu_op))
      OP_R: begin
        if (funct7 == F7_MEXT) begin
`ifdef ALU_DEC_MEXT_EN
          dec.alu_ctrl = ALU_MEXT;
          dec.mc       = 1'b1;
          dec.mfn      = funct3;
`else
          dec.illegal  = 1'b1;
`endif
        end else begin
          case ({funct3, alt})
            4'b0000: dec.alu_ctrl = ALU_ADD;
            4'b0001: dec.alu_ctrl = ALU_SUB;
            4'b1000: dec.alu_ctrl = ALU_XOR;
            4'b1100: dec.alu_ctrl = ALU_OR;
            4'b1110: dec.alu_ctrl = ALU_AND;
            4'b0010: dec.alu_ctrl = ALU_SLL;
            4'b1010: dec.alu_ctrl = ALU_SRL;
            4'b1011: dec.alu_ctrl = ALU_SRA;
            4'b0100: dec.alu_ctrl = ALU_SLT;
            4'b0110: dec.alu_ctrl = ALU_SLTU;
            default: dec.illegal  = 1'b1;
          endcase
        end
      end
      OP_I: begin
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_ADD;
          3'b100:  dec.alu_ctrl = ALU_XOR;
          3'b110:  dec.alu_ctrl = ALU_OR;
          3'b111:  dec.alu_ctrl = ALU_AND;
          3'b001:  dec.alu_ctrl = ALU_SLL;
          3'b010:  dec.alu_ctrl = ALU_SLT;
          3'b011:  dec.alu_ctrl = ALU_SLTU;
          default: dec.alu_ctrl = alt ? ALU_SRA : ALU_SRL;
        endcase
      end
      OP_LOAD: begin
        // address generation is always an add; only the width varies
        case (funct3)
          3'b000:  dec.mem     = MEM_LB;
          3'b001:  dec.mem     = MEM_LH;
          3'b010:  dec.mem     = MEM_LW;
          3'b100:  dec.mem     = MEM_LBU;
          3'b101:  dec.mem     = MEM_LHU;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: begin
        case (funct3)
          3'b000: begin dec.alu_ctrl = ALU_XOR;  dec.cmp = CMP_ZERO; end
          3'b001: begin dec.alu_ctrl = ALU_XOR;  dec.cmp = CMP_NZ;   end
          3'b100: begin dec.alu_ctrl = ALU_SLT;  dec.cmp = CMP_NZ;   end
          3'b101: begin dec.alu_ctrl = ALU_SLT;  dec.cmp = CMP_ZERO; end
          3'b110: begin dec.alu_ctrl = ALU_SLTU; dec.cmp = CMP_NZ;   end
          3'b111: begin dec.alu_ctrl = ALU_SLTU; dec.cmp = CMP_ZERO; end
          default: dec.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_pipe.sv
// ALU-control decoder with one registered valid/ready stage (1-cycle latency, holds under backpressure)
// and an M-op occupancy counter that stalls issue; counter exists only when ALU_DEC_MEXT_EN is defined.
module alu_decode_pipe
  import alu_dec_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [1:0]       in_alu_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_ctrl,
  output logic [1:0]       out_cmp,
  output logic [2:0]       out_mem,
  output logic             out_mc,
  output logic [2:0]       out_mfn,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  dec_t             dec_next;
  dec_t             dec_q;
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;
  logic             in_fire;
  logic             cnt_zero;

  alu_dec_comb u_comb (
    .instr  (in_instr),
    .alu_op (in_alu_op),
    .dec    (dec_next)
  );

  assign in_ready = cnt_zero && (!valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      tag_q   <= '0;
    end else if (in_fire) begin
      valid_q <= 1'b1;
      dec_q   <= dec_next;
      tag_q   <= in_tag;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ALU_DEC_MEXT_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

  logic [CNT_W-1:0] cnt;

  // A new M op can only be accepted while cnt is zero, so load never races decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (in_fire && dec_next.mc) begin
      cnt <= dec_next.mfn[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign cnt_zero = (cnt == '0);
  assign busy     = !cnt_zero;
  assign out_mfn  = dec_q.mfn;
`else
  localparam int unused_lat = MUL_LAT + DIV_LAT;
  logic          unused_mfn;

  assign cnt_zero   = 1'b1;
  assign busy       = 1'b0;
  assign out_mfn    = 3'b000;
  assign unused_mfn = ^dec_q.mfn;
`endif

  assign out_valid    = valid_q;
  assign out_alu_ctrl = dec_q.alu_ctrl;
  assign out_cmp      = dec_q.cmp;
  assign out_mem      = dec_q.mem;
  assign out_mc       = dec_q.mc;
  assign out_illegal  = dec_q.illegal;
  assign out_tag      = tag_q;

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Bench for alu_decode_pipe: directed cases plus random traffic against a mnemonic-level reference model.
module tb_alu_decode_pipe;

  localparam int TAG_W   = 5;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [1:0]       in_alu_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_alu_ctrl;
  logic [1:0]       out_cmp;
  logic [2:0]       out_mem;
  logic             out_mc;
  logic [2:0]       out_mfn;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  alu_decode_pipe #(.TAG_W(TAG_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_alu_op    (in_alu_op),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_cmp      (out_cmp),
    .out_mem      (out_mem),
    .out_mc       (out_mc),
    .out_mfn      (out_mfn),
    .out_illegal  (out_illegal),
    .out_tag      (out_tag),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] cmp;
    logic [2:0] mem;
    logic       mc;
    logic [2:0] mfn;
    logic       ill;
    logic [7:0] lat;
  } exp_t;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               free_cyc = 0;
  logic             m_valid = 1'b0;
  exp_t             m_dec = '0;
  logic [TAG_W-1:0] m_tag = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: name the instruction first, then map the name to its control fields.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [1:0] op);
    string      m;
    exp_t       e;
    logic [2:0] f3;
    logic       alt;
    f3  = ins[14:12];
    alt = ins[30];
    e   = '0;
    m   = "ILL";
    case (op)
      2'b00: begin
        if (ins[31:25] == 7'b0000001) begin
`ifdef ALU_DEC_MEXT_EN
          m = "MDU";
`endif
        end else begin
          case (f3)
            3'd0: m = alt ? "SUB" : "ADD";
            3'd1: if (!alt) m = "SLL";
            3'd2: if (!alt) m = "SLT";
            3'd3: if (!alt) m = "SLTU";
            3'd4: if (!alt) m = "XOR";
            3'd5: m = alt ? "SRA" : "SRL";
            3'd6: if (!alt) m = "OR";
            default: if (!alt) m = "AND";
          endcase
        end
      end
      2'b01: begin
        case (f3)
          3'd0: m = "ADD";  3'd1: m = "SLL"; 3'd2: m = "SLT"; 3'd3: m = "SLTU";
          3'd4: m = "XOR";  3'd5: m = alt ? "SRA" : "SRL";
          3'd6: m = "OR";   default: m = "AND";
        endcase
      end
      2'b10: begin
        case (f3)
          3'd0: m = "LB"; 3'd1: m = "LH"; 3'd2: m = "LW";
          3'd4: m = "LBU"; 3'd5: m = "LHU"; default: m = "ILL";
        endcase
      end
      default: begin
        case (f3)
          3'd0: m = "BEQ"; 3'd1: m = "BNE"; 3'd4: m = "BLT";
          3'd5: m = "BGE"; 3'd6: m = "BLTU"; 3'd7: m = "BGEU"; default: m = "ILL";
        endcase
      end
    endcase
    case (m)
      "AND":  e.alu = 4'h0;
      "OR":   e.alu = 4'h1;
      "ADD":  e.alu = 4'h2;
      "XOR":  e.alu = 4'h3;
      "SLL":  e.alu = 4'h4;
      "SLT":  e.alu = 4'h5;
      "SUB":  e.alu = 4'h6;
      "SLTU": e.alu = 4'h7;
      "SRL":  e.alu = 4'h8;
      "SRA":  e.alu = 4'h9;
      "LB":   begin e.alu = 4'h2; e.mem = 3'd1; end
      "LH":   begin e.alu = 4'h2; e.mem = 3'd2; end
      "LW":   begin e.alu = 4'h2; e.mem = 3'd3; end
      "LBU":  begin e.alu = 4'h2; e.mem = 3'd5; end
      "LHU":  begin e.alu = 4'h2; e.mem = 3'd6; end
      "BEQ":  begin e.alu = 4'h3; e.cmp = 2'b11; end
      "BNE":  begin e.alu = 4'h3; e.cmp = 2'b10; end
      "BLT":  begin e.alu = 4'h5; e.cmp = 2'b10; end
      "BGE":  begin e.alu = 4'h5; e.cmp = 2'b11; end
      "BLTU": begin e.alu = 4'h7; e.cmp = 2'b10; end
      "BGEU": begin e.alu = 4'h7; e.cmp = 2'b11; end
      "MDU":  begin
        e.alu = 4'hF; e.mc = 1'b1; e.mfn = f3;
        e.lat = f3[2] ? 8'(DIV_LAT) : 8'(MUL_LAT);
      end
      default: begin e.alu = 4'h2; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    logic [31:0] r;
    r        = $urandom;
    r[31:25] = f7;
    r[14:12] = f3;
    return r;
  endfunction

  task automatic compare_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("alu_ctrl", 32'(out_alu_ctrl), 32'(m_dec.alu));
    check("cmp", 32'(out_cmp), 32'(m_dec.cmp));
    check("mem", 32'(out_mem), 32'(m_dec.mem));
    check("mc", 32'(out_mc), 32'(m_dec.mc));
    check("mfn", 32'(out_mfn), 32'(m_dec.mfn));
    check("illegal", 32'(out_illegal), 32'(m_dec.ill));
    check("tag", 32'(out_tag), 32'(m_tag));
    check("busy", 32'(busy), 32'(cyc < free_cyc));
  endtask

  // One clock cycle: drive, check against model, clock, advance model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [1:0] op,
                      input logic [TAG_W-1:0] tg, input logic ordy);
    logic m_rdy;
    logic fire;
    exp_t e;
    int   nfree;
    in_valid  = v;
    in_instr  = ins;
    in_alu_op = op;
    in_tag    = tg;
    out_ready = ordy;
    #1;
    m_rdy = (cyc >= free_cyc) && (!m_valid || ordy);
    compare_outputs();
    check("in_ready", 32'(in_ready), 32'(m_rdy));
    fire  = v && m_rdy;
    e     = ref_decode(ins, op);
    nfree = (fire && e.mc) ? cyc + int'(e.lat) : free_cyc;
    @(posedge clk);
    #1;
    cyc++;
    free_cyc = nfree;
    if (fire) begin
      m_valid = 1'b1;
      m_dec   = e;
      m_tag   = tg;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_dec    = '0;
    m_tag    = '0;
    free_cyc = 0;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 2'b00, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_alu_op = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_fields", 32'({out_alu_ctrl, out_cmp, out_mem, out_mc, out_mfn, out_illegal}), 0);
    check("rst_tag", 32'(out_tag), 0);
    @(posedge clk);
    #1;

    // R-type stream: SUB, SRA, SLTU back to back
    step(1'b1, mk(7'b0100000, 3'b000), 2'b00, 5'h01, 1'b1);
    check("r_sub", 32'(out_alu_ctrl), 6);
    check("r_sub_vld", 32'(out_valid), 1);
    step(1'b1, mk(7'b0100000, 3'b101), 2'b00, 5'h02, 1'b1);
    check("r_sra", 32'(out_alu_ctrl), 9);
    check("r_sra_tag", 32'(out_tag), 2);
    step(1'b1, mk(7'b0000000, 3'b011), 2'b00, 5'h03, 1'b1);
    check("r_sltu", 32'(out_alu_ctrl), 7);

    step(1'b1, mk(7'h00, 3'b101), 2'b10, 5'h04, 1'b1);
    check("lhu_alu", 32'(out_alu_ctrl), 2);
    check("lhu_mem", 32'(out_mem), 6);
    step(1'b1, mk(7'h00, 3'b011), 2'b10, 5'h05, 1'b1);
    check("ld_ill", 32'(out_illegal), 1);
    check("ld_ill_alu", 32'(out_alu_ctrl), 2);
    check("ld_ill_mem", 32'(out_mem), 0);
    step(1'b1, mk(7'h00, 3'b001), 2'b11, 5'h06, 1'b1);
    check("bne_alu", 32'(out_alu_ctrl), 3);
    check("bne_cmp", 32'(out_cmp), 2);
    step(1'b1, mk(7'h00, 3'b111), 2'b11, 5'h07, 1'b1);
    check("bgeu_alu", 32'(out_alu_ctrl), 7);
    check("bgeu_cmp", 32'(out_cmp), 3);

`ifndef ALU_DEC_MEXT_EN
    step(1'b1, mk(7'b0000001, 3'b000), 2'b00, 5'h08, 1'b1);
    check("mext_off_ill", 32'(out_illegal), 1);
    check("mext_off_mc", 32'(out_mc), 0);
    check("mext_off_busy", 32'(busy), 0);
`endif

    // Backpressure: A held for 3 cycles while B waits
    step(1'b1, mk(7'h00, 3'b000), 2'b01, 5'h0A, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(7'h00, 3'b100), 2'b01, 5'h0B, 1'b0);
      check("bp_tag", 32'(out_tag), 32'h0A);
      check("bp_alu", 32'(out_alu_ctrl), 2);
      check("bp_vld", 32'(out_valid), 1);
      check("bp_rdy", 32'(in_ready), 0);
    end
    step(1'b1, mk(7'h00, 3'b100), 2'b01, 5'h0B, 1'b1);
    check("bp_b_tag", 32'(out_tag), 32'h0B);
    check("bp_b_alu", 32'(out_alu_ctrl), 3);
    step(1'b1, mk(7'h00, 3'b110), 2'b01, 5'h0C, 1'b1);
    check("bp_c_tag", 32'(out_tag), 32'h0C);
    check("bp_c_alu", 32'(out_alu_ctrl), 1);

`ifdef ALU_DEC_MEXT_EN
    begin
      int n;
      step(1'b1, mk(7'b0000001, 3'b000), 2'b00, 5'h10, 1'b1);
      check("mul_mc", 32'(out_mc), 1);
      check("mul_rdy_t1", 32'(in_ready), 0);
      idle();
      check("mul_rdy_t2", 32'(in_ready), 0);
      idle();
      check("mul_rdy_t3", 32'(in_ready), 1);

      step(1'b1, mk(7'b0000001, 3'b101), 2'b00, 5'h11, 1'b1);
      check("divu_mfn", 32'(out_mfn), 5);
      check("divu_alu", 32'(out_alu_ctrl), 15);
      n = 0;
      while (in_ready == 1'b0 && n < 100) begin
        idle();
        n++;
      end
      check("divu_stall", 32'(n), 32);

      step(1'b1, mk(7'b0000001, 3'b100), 2'b00, 5'h12, 1'b1);
      repeat (9) idle();
      check("pre_rst_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_vld", 32'(out_valid), 0);
      model_reset();
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
`endif

    for (int i = 0; i < 600; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        2:       f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), mk(f7, 3'($urandom)), 2'($urandom),
           TAG_W'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_pipe.md
# alu_decode_pipe

Registered, handshaked ALU-control decoder for the impostor_32 core. It sits between instruction decode and execute. It maps each instruction word plus its 2-bit ALU-op class to:

- an ALU control code
- a branch-compare mode
- a load-width code
- an illegal flag

It also throttles issue of multi-cycle M-extension operations with an internal occupancy counter.

## Interface
- TAG_W, 5 — width of the sideband tag (e.g. ROB/dest index) carried alongside each instruction
- MUL_LAT, 3 — execute occupancy in cycles of MUL/MULH/MULHSU/MULHU; legal range ≥1
- DIV_LAT, 33 — execute occupancy in cycles of DIV/DIVU/REM/REMU; legal range ≥1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  block accepts this cycle
- in_instr  in  32  instruction word
- in_alu_op  in  2  class: 00 R-type, 01 I-type ALU, 10 load, 11 branch
- in_tag  in  TAG_W  passthrough sideband
- out_valid  out  1  decoded result held
- out_ready  in  1  execute consumes
- out_alu_ctrl  out  4  ALU code, defined in pkg
- out_cmp  out  2  00 none, 11 take-if-zero, 10 take-if-nonzero
- out_mem  out  3  000 none, 001 LB, 010 LH, 011 LW, 101 LBU, 110 LHU
- out_mc  out  1  multi-cycle M op
- out_mfn  out  3  M-op funct3, 0 otherwise
- out_illegal  out  1  unmapped encoding
- out_tag  out  TAG_W  registered in_tag
- busy  out  1  occupancy counter nonzero

## Operation
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SLT 0101
  - SUB 0110, SLTU 0111, SRL 1000, SRA 1001, MEXT 1111
- R-type (00), key {instr[14:12],instr[30]}:
  - 0000 ADD, 0001 SUB, 1000 XOR, 1100 OR, 1110 AND
  - 0010 SLL, 1010 SRL, 1011 SRA, 0100 SLT, 0110 SLTU
- I-type (01), by funct3:
  - 000 ADD, 100 XOR, 110 OR, 111 AND, 001 SLL, 010 SLT, 011 SLTU
  - 101 is SRL if instr[30]=0, else SRA
- Load (10): ALU ADD; out_mem as listed for funct3 000/001/010/100/101; other funct3 illegal.
- Branch (11):
  - 000 XOR/11
  - 001 XOR/10
  - 100 SLT/10
  - 101 SLT/11
  - 110 SLTU/10
  - 111 SLTU/11
  - 010/011 illegal
- Illegal encoding: out_illegal=1, ADD, cmp 00, mem 000, mc 0. The entry still flows downstream.
- Non-applicable fields are 0.
- One output register stage:
  - in_ready = (cnt==0) && (!out_valid || out_ready)
  - The output register loads on the in handshake.
  - out_valid clears on an out handshake with no simultaneous load.
- Occupancy counter:
  - An accepted M op loads cnt = LAT-1, where LAT is MUL_LAT if funct3[2]=0, else DIV_LAT.
  - cnt decrements by 1 each cycle while nonzero.
  - busy = (cnt!=0).
  - LAT=1 produces no stall.
- Outputs hold stable while out_valid && !out_ready.

## Timing
- Reset: all outputs 0 except in_ready, which is 1 after reset; cnt = 0.
- Latency: 1 cycle from in handshake to out_valid.
- Throughput: 1 per cycle for non-M ops with out_ready held high.
- Simultaneous out handshake and in handshake in the same cycle: the register reloads and out_valid stays 1.
- After an M op with latency L accepted at cycle t: in_ready is low for cycles t+1 … t+L-1 and returns high at t+L, subject to the output condition.
- An rst_n assertion mid-stall clears cnt and out_valid immediately.

## Configuration
- ALU_DEC_MEXT_EN defined:
  - R-type with instr[31:25]=0000001 decodes as M op: out_alu_ctrl=1111, out_mc=1, out_mfn=funct3.
  - The counter operates as described.
- ALU_DEC_MEXT_EN undefined:
  - The same encoding is flagged illegal.
  - The counter is removed; busy is tied 0 and out_mfn is tied 0.

## Structure
- Package alu_dec_pkg holds:
  - ALU code localparams
  - cmp and mem code constants
  - a decoded-result struct (alu_ctrl, cmp, mem, mc, mfn, illegal)
- Sub-module alu_dec_comb holds the pure combinational decode function (instr, alu_op → struct).
- The top module holds the handshake register and the occupancy counter.

## Test plan
- Reset:
  - Stimulus: rst_n=0, then release.
  - Required: out_valid=0, busy=0, in_ready=1, all fields 0.
- R-type stream:
  - Stimulus: instructions with key 0001, 1011 and 0110, out_ready=1.
  - Required: SUB 0110, SRA 1001, SLTU 0111 on consecutive cycles, 1-cycle latency.
- Load LHU:
  - Stimulus: funct3 101 with alu_op 10.
  - Required: ADD, mem 110.
- Load illegal:
  - Stimulus: funct3 011 with alu_op 10.
  - Required: illegal=1, ADD, mem 000.
- Branches:
  - Stimulus: BNE (001) with alu_op 11.
  - Required: XOR, cmp 10.
  - Stimulus: BGEU (111) with alu_op 11.
  - Required: SLTU, cmp 11.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid held.
  - Required: outputs and tag stable, in_ready=0; one transfer per cycle resumes once out_ready=1.
- M-extension (ALU_DEC_MEXT_EN, MUL_LAT=3, DIV_LAT=33):
  - Stimulus: MUL accepted at t.
  - Required: in_ready low at t+1 and t+2, high at t+3.
  - Stimulus: DIVU (funct3 101).
  - Required: out_mfn=101 and 32 stall cycles.
  - Stimulus: rst_n pulse at stall cycle 10.
  - Required: busy=0 immediately.
